// File: rtl/led_breath_pwm_if.sv
// Signal bundle between the PLL-domain top level and the LED breathing PWM block.
// No valid/ready handshake: en_i is a level enable sampled every clock, lock_i is
// asynchronous and synchronized inside the block, all outputs are registered levels.
interface led_breath_pwm_if #(
    parameter int NUM_LED = 5
);
    logic               lock_i;
    logic               en_i;
    logic [NUM_LED-1:0] led_o;
    logic               cyc_o;
    logic               run_o;
    logic [1:0]         state_o;

    modport master (
        output lock_i, en_i,
        input  led_o, cyc_o, run_o, state_o
    );

    modport slave (
        input  lock_i, en_i,
        output led_o, cyc_o, run_o, state_o
    );
endinterface

// File: rtl/led_breath_pwm.sv
// Phase-staggered breathing PWM for the LED bank, held dark until the PLL lock
// has been continuously high for LOCK_FILTER synchronized cycles.
module led_breath_pwm #(
    parameter int NUM_LED     = 5,
    parameter int PWM_BITS    = 8,
    parameter int STEP_DIV    = 234375,
    parameter int PHASE_OFS   = 102,
    parameter int LOCK_FILTER = 1024
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    led_breath_pwm_if.slave   bus
);
    localparam int ACC_W = PWM_BITS + 1;
    localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int LCK_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;

    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [LCK_W-1:0]    LCK_LAST = LCK_W'(LOCK_FILTER - 1);
    localparam logic [PRE_W-1:0]    PRE_ONE  = PRE_W'(1);
    localparam logic [LCK_W-1:0]    LCK_ONE  = LCK_W'(1);
    localparam logic [ACC_W-1:0]    ACC_ONE  = ACC_W'(1);
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RUN       = 2'd1,
        PAUSE     = 2'd2
    } state_t;

    state_t                            state_q, state_d;
    logic                              lock_m, lock_s;
    logic [LCK_W-1:0]                  lock_cnt;
    logic [PRE_W-1:0]                  presc;
    logic [ACC_W-1:0]                  acc;
    logic [PWM_BITS-1:0]               pwm_cnt;
    logic [NUM_LED-1:0][PWM_BITS-1:0]  duty_q;
    logic [NUM_LED-1:0][PWM_BITS-1:0]  duty_next;
    logic [NUM_LED-1:0]                led_q, led_cmp;
    logic                              cyc_q;
    logic                              run_step, clear, tick;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= bus.lock_i;
            lock_s <= lock_m;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= WAIT_LOCK;
        else          state_q <= state_d;
    end

    // Lock loss is checked first in every state so it always wins over en_i.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOCK: if (lock_s && lock_cnt == LCK_LAST) state_d = bus.en_i ? RUN : PAUSE;
            RUN: begin
                if (!lock_s)         state_d = WAIT_LOCK;
                else if (!bus.en_i)  state_d = PAUSE;
            end
            PAUSE: begin
                if (!lock_s)         state_d = WAIT_LOCK;
                else if (bus.en_i)   state_d = RUN;
            end
            default:                 state_d = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            lock_cnt <= '0;
        else if (state_q == WAIT_LOCK && lock_s && lock_cnt != LCK_LAST)
            lock_cnt <= lock_cnt + LCK_ONE;
        else
            lock_cnt <= '0;
    end

    assign run_step = (state_q == RUN) && lock_s && bus.en_i;
    assign clear    = !lock_s || (state_q == WAIT_LOCK);
    assign tick     = run_step && (presc == PRE_LAST);

    // Triangle fold of each channel's phase: rising on the lower half, falling on the upper.
    for (genvar k = 0; k < NUM_LED; k++) begin : g_ch
        logic [ACC_W-1:0] phase;
        assign phase        = acc + ACC_W'(k * PHASE_OFS);
        assign duty_next[k] = phase[PWM_BITS] ? ~phase[PWM_BITS-1:0] : phase[PWM_BITS-1:0];
        assign led_cmp[k]   = pwm_cnt < duty_q[k];
    end

    // duty_q only reloads on the last PWM count so each period uses one duty throughout.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            presc   <= '0;
            acc     <= '0;
            pwm_cnt <= '0;
            duty_q  <= '0;
            led_q   <= '0;
            cyc_q   <= 1'b0;
        end else if (clear) begin
            presc   <= '0;
            acc     <= '0;
            pwm_cnt <= '0;
            duty_q  <= '0;
            led_q   <= '0;
            cyc_q   <= 1'b0;
        end else begin
            cyc_q <= tick && (&acc);
            if (run_step) begin
                presc   <= tick ? '0 : presc + PRE_ONE;
                pwm_cnt <= pwm_cnt + PWM_ONE;
                led_q   <= led_cmp;
                if (tick)      acc    <= acc + ACC_ONE;
                if (&pwm_cnt)  duty_q <= duty_next;
            end else begin
                led_q <= '0;
            end
        end
    end

    assign bus.led_o   = led_q;
    assign bus.cyc_o   = cyc_q;
    assign bus.run_o   = (state_q == RUN);
    assign bus.state_o = state_q;
endmodule

// File: tb/tb_led_breath_pwm.sv
// Directed bench for led_breath_pwm with small parameters so a full breathing
// period (32 ticks x 4 clocks) fits in a short run.
module tb_led_breath_pwm;
  localparam int NUM_LED     = 5;
  localparam int PWM_BITS    = 4;
  localparam int STEP_DIV    = 4;
  localparam int PHASE_OFS   = 8;
  localparam int LOCK_FILTER = 8;

  logic clk;
  logic rst_n;

  led_breath_pwm_if #(.NUM_LED(NUM_LED)) bus ();

  led_breath_pwm #(
    .NUM_LED(NUM_LED),
    .PWM_BITS(PWM_BITS),
    .STEP_DIV(STEP_DIV),
    .PHASE_OFS(PHASE_OFS),
    .LOCK_FILTER(LOCK_FILTER)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [PWM_BITS-1:0] exp_q[$];
  logic [PWM_BITS-1:0] exp_d1 [8] = '{4'd11, 4'd15, 4'd12, 4'd8, 4'd4, 4'd0, 4'd3, 4'd7};
  logic [15:0] exp_pat [8] = '{16'h000E, 16'h00FE, 16'h0FFE, 16'hFFFE,
                               16'h1FFE, 16'h01FE, 16'h001E, 16'h0000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // driver
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_run(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (bus.run_o) begin
        lat = i;
        break;
      end
    end
  endtask

  int   lat;
  int   cyc_cnt;
  int   cyc_pos [2];
  logic [NUM_LED-1:0] led_seen;
  logic run_seen, cyc_seen, found;
  logic [15:0] pat;

  initial begin
    rst_n      = 1'b0;
    bus.lock_i = 1'b0;
    bus.en_i   = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_led",   32'(bus.led_o), 0);
    check("rst_cyc",   32'(bus.cyc_o), 0);
    check("rst_run",   32'(bus.run_o), 0);
    check("rst_state", 32'(bus.state_o), 0);
    check("rst_acc",   32'(dut.acc), 0);

    // lock filter: lock high from release
    bus.lock_i = 1'b1;
    rst_n      = 1'b1;
    led_seen   = '0;
    lat        = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (bus.run_o) begin
        lat = i;
        break;
      end
      led_seen |= bus.led_o;
    end
    check("lock_latency", 32'(lat), 10);
    check("dark_before_run", 32'(led_seen), 0);

    // lock glitch at filter count 5
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      if (dut.lock_cnt == 3'd5) begin
        found = 1'b1;
        break;
      end
    end
    check("glitch_cnt5", 32'(found), 1);
    bus.lock_i = 1'b0;
    step(1);
    bus.lock_i = 1'b1;
    step(1);
    check("glitch_lock_s_low", 32'(dut.lock_s), 0);
    step(1);
    check("glitch_lock_s_high", 32'(dut.lock_s), 1);
    check("glitch_cnt_restart", 32'(dut.lock_cnt), 0);
    wait_run(lat);
    check("glitch_latency", 32'(lat), 8);

    // duty triangle, PWM compare and cycle pulse
    check("entry_acc",   32'(dut.acc), 0);
    check("entry_presc", 32'(dut.presc), 0);
    check("entry_pwm",   32'(dut.pwm_cnt), 0);
    exp_q = '{4'd3, 4'd7, 4'd11, 4'd15, 4'd12, 4'd8, 4'd4, 4'd0};
    cyc_cnt = 0;
    cyc_pos = '{0, 0};
    pat = '0;
    for (int c = 1; c <= 262; c++) begin
      step(1);
      if (c % 16 == 0 && c >= 16 && c <= 128) begin
        check($sformatf("duty0_p%0d", c / 16), 32'(dut.duty_q[0]), 32'(exp_q.pop_front()));
        check($sformatf("duty1_p%0d", c / 16), 32'(dut.duty_q[1]), 32'(exp_d1[c / 16 - 1]));
      end
      if (c >= 16 && c < 144) begin
        pat[c % 16] = bus.led_o[0];
        if (c % 16 == 15)
          check($sformatf("led0_pat_p%0d", c / 16), 32'(pat), 32'(exp_pat[c / 16 - 1]));
      end
      if (bus.cyc_o) begin
        if (cyc_cnt < 2) cyc_pos[cyc_cnt] = c;
        cyc_cnt++;
      end
    end
    check("cyc_count",  32'(cyc_cnt), 2);
    check("cyc_first",  32'(cyc_pos[0]), 128);
    check("cyc_second", 32'(cyc_pos[1]), 256);

    // pause at c=262: presc 2, acc 1, pwm 6
    bus.en_i = 1'b0;
    led_seen = '0;
    run_seen = 1'b0;
    cyc_seen = 1'b0;
    repeat (50) begin
      step(1);
      led_seen |= bus.led_o;
      run_seen |= bus.run_o;
      cyc_seen |= bus.cyc_o;
    end
    check("pause_led",   32'(led_seen), 0);
    check("pause_run",   32'(run_seen), 0);
    check("pause_cyc",   32'(cyc_seen), 0);
    check("pause_state", 32'(bus.state_o), 2);
    check("pause_presc", 32'(dut.presc), 2);
    check("pause_acc",   32'(dut.acc), 1);
    check("pause_pwm",   32'(dut.pwm_cnt), 6);
    bus.en_i = 1'b1;
    step(1);
    check("resume_run",    32'(bus.run_o), 1);
    check("resume_presc0", 32'(dut.presc), 2);
    step(1);
    check("resume_presc1", 32'(dut.presc), 3);
    check("resume_acc1",   32'(dut.acc), 1);
    step(1);
    check("resume_presc2", 32'(dut.presc), 0);
    check("resume_acc2",   32'(dut.acc), 2);

    // lock loss in RUN
    bus.lock_i = 1'b0;
    step(2);
    check("loss_still_run", 32'(bus.run_o), 1);
    step(1);
    check("loss_run",      32'(bus.run_o), 0);
    check("loss_state",    32'(bus.state_o), 0);
    check("loss_acc",      32'(dut.acc), 0);
    check("loss_presc",    32'(dut.presc), 0);
    check("loss_pwm",      32'(dut.pwm_cnt), 0);
    check("loss_lock_cnt", 32'(dut.lock_cnt), 0);
    check("loss_duty0",    32'(dut.duty_q[0]), 0);
    check("loss_led",      32'(bus.led_o), 0);
    check("loss_cyc",      32'(bus.cyc_o), 0);

    // asynchronous reset mid-period
    bus.lock_i = 1'b1;
    wait_run(lat);
    check("relock_latency", 32'(lat), 10);
    step(17);
    check("pre_reset_led0", 32'(bus.led_o[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led",   32'(bus.led_o), 0);
    check("async_rst_run",   32'(bus.run_o), 0);
    check("async_rst_state", 32'(bus.state_o), 0);
    check("async_rst_acc",   32'(dut.acc), 0);
    check("async_rst_duty",  32'(dut.duty_q[0]), 0);

    // report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
